// File: rtl/axi_pkt_scheduler.sv
// ---------------------------------------------------------------------------
// axi_pkt_scheduler
//
// Shares one AXI-stream output between NUM_CHANNELS AXI-stream sources using
// packet-granular weighted round-robin. A grant is held for a whole packet.
// A channel may keep its grant for up to weight_i[channel] consecutive
// packets. Packets longer than MAX_PACKET_SIZE beats are cut: the output sees
// a forced tlast, the remaining source beats are swallowed, and a one-cycle
// error pulse is raised on that channel.
//
// Ports
//   clk_i           rising-edge clock
//   rst_i           synchronous reset, active high
//   s_valid_i       per-channel tvalid
//   s_ready_o       per-channel tready
//   s_data_i        per-channel tdata, channel k at [k*DATA_SIZE +: DATA_SIZE]
//   s_id_i          per-channel tid, same packing
//   s_last_i        per-channel tlast
//   weight_i        per-channel packets per turn (0 behaves as 1)
//   m_valid_o       output tvalid
//   m_ready_i       output tready
//   m_data_o        output tdata
//   m_id_o          output tid
//   m_last_o        output tlast (source tlast or forced cut)
//   m_chan_o        index of the granted channel
//   err_oversize_o  one-cycle pulse on the channel whose packet was cut
// ---------------------------------------------------------------------------
module axi_pkt_scheduler #(
    parameter int NUM_CHANNELS    = 4,
    parameter int DATA_SIZE       = 32,
    parameter int ID_SIZE         = 8,
    parameter int MAX_PACKET_SIZE = 4,
    parameter int WEIGHT_W        = 4,
    parameter int CHANNELS_W      = $clog2(NUM_CHANNELS)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_CHANNELS-1:0]          s_valid_i,
    output logic [NUM_CHANNELS-1:0]          s_ready_o,
    input  logic [NUM_CHANNELS*DATA_SIZE-1:0] s_data_i,
    input  logic [NUM_CHANNELS*ID_SIZE-1:0]  s_id_i,
    input  logic [NUM_CHANNELS-1:0]          s_last_i,
    input  logic [NUM_CHANNELS*WEIGHT_W-1:0] weight_i,
    output logic                             m_valid_o,
    input  logic                             m_ready_i,
    output logic [DATA_SIZE-1:0]             m_data_o,
    output logic [ID_SIZE-1:0]               m_id_o,
    output logic                             m_last_o,
    output logic [CHANNELS_W-1:0]            m_chan_o,
    output logic [NUM_CHANNELS-1:0]          err_oversize_o
);

    localparam int BEAT_W = (MAX_PACKET_SIZE > 1) ? $clog2(MAX_PACKET_SIZE) : 1;
    localparam int SCAN_W = CHANNELS_W + 1;
    localparam logic [SCAN_W-1:0] NUM_CH_S = SCAN_W'(NUM_CHANNELS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_PACKET_SIZE - 1);
    localparam logic [CHANNELS_W-1:0] LAST_CH = CHANNELS_W'(NUM_CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DROP
    } state_t;

    state_t                  state_q, state_d;
    logic [CHANNELS_W-1:0]   grant_q, grant_d;
    logic [CHANNELS_W-1:0]   rrPtr_q, rrPtr_d;
    logic [WEIGHT_W-1:0]     credit_q, credit_d;
    logic [BEAT_W-1:0]       beatCnt_q, beatCnt_d;
    logic [NUM_CHANNELS-1:0] errOversize_q, errOversize_d;

    logic [DATA_SIZE-1:0]    dataArr   [NUM_CHANNELS];
    logic [ID_SIZE-1:0]      idArr     [NUM_CHANNELS];
    logic [WEIGHT_W-1:0]     weightArr [NUM_CHANNELS];

    logic                    pickValid;
    logic [CHANNELS_W-1:0]   pick;
    logic [SCAN_W-1:0]       scanIdx;
    logic [CHANNELS_W-1:0]   nextChan;
    logic                    atMaxBeat;

    // Unpack the flat per-channel buses into arrays so the granted channel can
    // be selected with a plain index instead of part-select arithmetic.
    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : gUnpack
        assign dataArr[g]   = s_data_i[g*DATA_SIZE +: DATA_SIZE];
        assign idArr[g]     = s_id_i[g*ID_SIZE +: ID_SIZE];
        assign weightArr[g] = weight_i[g*WEIGHT_W +: WEIGHT_W];
    end

    assign nextChan       = (grant_q == LAST_CH) ? '0 : grant_q + 1'b1;
    assign atMaxBeat      = (beatCnt_q == LAST_BEAT);
    assign err_oversize_o = errOversize_q;

    // Round-robin pick: scan upward from the pointer, wrapping at
    // NUM_CHANNELS, and take the first requesting channel. The pointer stays on
    // the current owner while it still has credit, so the same scan naturally
    // lets it keep the grant.
    always_comb begin
        pickValid = 1'b0;
        pick      = rrPtr_q;
        scanIdx   = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            scanIdx = {1'b0, rrPtr_q} + SCAN_W'(k);
            if (scanIdx >= NUM_CH_S) begin
                scanIdx = scanIdx - NUM_CH_S;
            end
            if (!pickValid && s_valid_i[scanIdx[CHANNELS_W-1:0]]) begin
                pickValid = 1'b1;
                pick      = scanIdx[CHANNELS_W-1:0];
            end
        end
    end

    // State register. Reset abandons any packet in flight and also clears a
    // pending error pulse, so a reset never reports an oversize.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rrPtr_q       <= '0;
            credit_q      <= '0;
            beatCnt_q     <= '0;
            errOversize_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rrPtr_q       <= rrPtr_d;
            credit_q      <= credit_d;
            beatCnt_q     <= beatCnt_d;
            errOversize_q <= errOversize_d;
        end
    end

    // Next-state and output logic. BUSY is a pure combinational pass-through
    // of the granted channel; m_valid_o only ever depends on s_valid_i and
    // registered state, never on m_ready_i. A new credit is loaded whenever
    // the grant moves to a different channel or the owner has used up its
    // turn, which also discards leftover credit of a channel that went quiet.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rrPtr_d       = rrPtr_q;
        credit_d      = credit_q;
        beatCnt_d     = beatCnt_q;
        errOversize_d = '0;
        s_ready_o     = '0;
        m_valid_o     = 1'b0;
        m_data_o      = '0;
        m_id_o        = '0;
        m_last_o      = 1'b0;
        m_chan_o      = grant_q;

        case (state_q)
            IDLE: begin
                if (pickValid) begin
                    grant_d = pick;
                    state_d = BUSY;
                    if ((pick != rrPtr_q) || (credit_q == '0)) begin
                        credit_d = (weightArr[pick] == '0) ? WEIGHT_W'(1) : weightArr[pick];
                    end
                end
            end

            BUSY: begin
                m_valid_o          = s_valid_i[grant_q];
                s_ready_o[grant_q] = m_ready_i;
                m_data_o           = dataArr[grant_q];
                m_id_o             = idArr[grant_q];
                m_last_o           = s_last_i[grant_q] || atMaxBeat;
                if (m_valid_o && m_ready_i) begin
                    if (m_last_o) begin
                        beatCnt_d = '0;
                        credit_d  = credit_q - WEIGHT_W'(1);
                        rrPtr_d   = (credit_q == WEIGHT_W'(1)) ? nextChan : grant_q;
                        if (s_last_i[grant_q]) begin
                            state_d = IDLE;
                        end else begin
                            state_d                = DROP;
                            errOversize_d[grant_q] = 1'b1;
                        end
                    end else begin
                        beatCnt_d = beatCnt_q + 1'b1;
                    end
                end
            end

            DROP: begin
                s_ready_o[grant_q] = 1'b1;
                if (s_valid_i[grant_q] && s_last_i[grant_q]) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
